// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit : multi-cycle radix-2 restoring divider for the MIPS EX stage.
//
// Computes quotient (lo_o) and remainder (hi_o) of a_i / b_i for DIV
// (signed_i=1, two's complement) and DIVU (signed_i=0). One operation is in
// flight at a time; busy stalls the pipeline while the divider iterates, and
// done pulses for one cycle when hi_o/lo_o carry a fresh result.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous, active-low reset
//   start     in   begin a division (accepted only when not iterating)
//   signed_i  in   1 = DIV, 0 = DIVU
//   a_i       in   dividend (rs)
//   b_i       in   divisor  (rt)
//   cancel    in   abort an in-flight division, suppresses done
//   busy      out  division in progress
//   done      out  one-cycle pulse, hi_o/lo_o valid
//   lo_o      out  quotient
//   hi_o      out  remainder
//
// Build option
//   DIV_ZERO_FAST_EN  when defined, a zero divisor skips the iteration and
//                     finishes one cycle after start. Results are the same
//                     in both builds: lo = all ones, hi = dividend as given.
// ---------------------------------------------------------------------------
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST_ZERO = 1'b1;
`else
  localparam bit FAST_ZERO = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;

  // Datapath state: not reset, only meaningful while CALC is active.
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             bzero_q, bzero_d;

  logic             a_neg, b_neg;
  logic [WIDTH:0]   shifted, diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_nx, quot_nx;

  // Two's complement negate when neg is set. The most negative value maps to
  // itself, which is exactly the magnitude/result wanted for 0x80..0.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic             neg);
    return neg ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  always_comb begin
    a_neg   = signed_i & a_i[WIDTH-1];
    b_neg   = signed_i & b_i[WIDTH-1];

    // One restoring step: the quotient register doubles as the dividend
    // shift register, its MSB feeds into the partial remainder.
    shifted = {rem_q, quot_q[WIDTH-1]};
    diff    = shifted - {1'b0, bmag_q};
    qbit    = ~diff[WIDTH];
    rem_nx  = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quot_nx = {quot_q[WIDTH-2:0], qbit};

    state_d   = state_q;
    count_d   = count_q;
    done_d    = 1'b0;
    lo_d      = lo_q;
    hi_d      = hi_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    bmag_d    = bmag_q;
    a_d       = a_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    bzero_d   = bzero_q;

    case (state_q)
      CALC: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          rem_d   = rem_nx;
          quot_d  = quot_nx;
          count_d = count_q + CNT_W'(1);
          // Final step registers the signed-corrected result directly so that
          // done and the result appear together on the cycle after.
          if (count_q == LAST_CNT) begin
            state_d = DONE;
            done_d  = 1'b1;
            if (bzero_q) begin
              lo_d = '1;
              hi_d = a_q;
            end else begin
              lo_d = cond_neg(quot_nx, quo_neg_q);
              hi_d = cond_neg(rem_nx, rem_neg_q);
            end
          end
        end
      end
      default: begin
        // IDLE and DONE both accept a new operation, which allows a start on
        // the done cycle. cancel suppresses a simultaneous start.
        state_d = IDLE;
        if (start && !cancel) begin
          a_d       = a_i;
          bmag_d    = cond_neg(b_i, b_neg);
          quot_d    = cond_neg(a_i, a_neg);
          rem_d     = '0;
          count_d   = '0;
          quo_neg_d = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          bzero_d   = (b_i == '0);
          if (FAST_ZERO && (b_i == '0)) begin
            state_d = DONE;
            done_d  = 1'b1;
            lo_d    = '1;
            hi_d    = a_i;
          end else begin
            state_d = CALC;
          end
        end
      end
    endcase

    busy_d = (state_d == CALC);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
    rem_q     <= rem_d;
    quot_q    <= quot_d;
    bmag_q    <= bmag_d;
    a_q       <= a_d;
    quo_neg_q <= quo_neg_d;
    rem_neg_q <= rem_neg_d;
    bzero_q   <= bzero_d;
  end

  assign busy = busy_q;
  assign done = done_q;
  assign lo_o = lo_q;
  assign hi_o = hi_q;

endmodule
